// File: rtl/alu_issue_ctrl_pkg.sv
// Shared definitions for the ALU issue/writeback stage.
// Holds the opcode encodings, the flag bit indices, the instruction field positions,
// the FSM state type and the opcode-to-ALU mapping helper.
package alu_issue_ctrl_pkg;

    // Instruction opcodes (instr[15:12])
    localparam logic [3:0] OP_NOP   = 4'h0;
    localparam logic [3:0] OP_LDI   = 4'h1;
    localparam logic [3:0] OP_MOV   = 4'h2;
    localparam logic [3:0] OP_MOV_B = 4'h3;
    localparam logic [3:0] OP_AND   = 4'h4;
    localparam logic [3:0] OP_OR    = 4'h5;
    localparam logic [3:0] OP_XOR   = 4'h6;
    localparam logic [3:0] OP_NOT   = 4'h7;
    localparam logic [3:0] OP_INC   = 4'h8;
    localparam logic [3:0] OP_DEC   = 4'h9;
    localparam logic [3:0] OP_ADD   = 4'hA;
    localparam logic [3:0] OP_SUB   = 4'hB;
    localparam logic [3:0] OP_SHL   = 4'hC;
    localparam logic [3:0] OP_SHR   = 4'hD;
    localparam logic [3:0] OP_ROL   = 4'hE;
    localparam logic [3:0] OP_ROR   = 4'hF;

    // ALU opcode 0000 forwards operand A unchanged
    localparam logic [3:0] ALU_PASS_A = 4'h0;

    // Flag bit indices in the ALU flags byte
    localparam int unsigned FLG_Z = 0;
    localparam int unsigned FLG_C = 1;
    localparam int unsigned FLG_N = 2;
    localparam int unsigned FLG_V = 7;

    // Instruction field bit positions
    localparam int unsigned OPC_MSB = 15;
    localparam int unsigned OPC_LSB = 12;
    localparam int unsigned RD_MSB  = 11;
    localparam int unsigned RD_LSB  = 9;
    localparam int unsigned RS1_MSB = 8;
    localparam int unsigned RS1_LSB = 6;
    localparam int unsigned RS2_MSB = 5;
    localparam int unsigned RS2_LSB = 3;
    localparam int unsigned X_MSB   = 3;
    localparam int unsigned X_LSB   = 0;
    localparam int unsigned IMM_MSB = 8;

    typedef enum logic [1:0] {IDLE, ISSUE, WRITE} state_e;

    // Opcode driven to the ALU. NOP/LDI/MOV use pass-A; a zero-width rotate is
    // undefined in the ALU, so it is turned into pass-A (result = A).
    function automatic logic [3:0] alu_op_map(input logic [3:0] op, input logic [3:0] x);
        logic [3:0] res;
        res = op;
        if (op == OP_NOP || op == OP_LDI || op == OP_MOV || op == OP_MOV_B) begin
            res = ALU_PASS_A;
        end
        if ((op == OP_ROL || op == OP_ROR) && x == 4'h0) begin
            res = ALU_PASS_A;
        end
        return res;
    endfunction

endpackage

// File: rtl/alu_issue_ctrl_if.sv
// Instruction handshake bundle between an instruction source and the issue stage.
//   instr_valid : instruction word present (source -> stage)
//   instr_ready : stage can accept (stage -> source)
//   instr       : 16-bit instruction word (source -> stage)
interface alu_issue_ctrl_if;
    logic        instr_valid;
    logic        instr_ready;
    logic [15:0] instr;

    modport master (output instr_valid, output instr, input instr_ready);
    modport slave  (input instr_valid, input instr, output instr_ready);
endinterface

// File: rtl/alu_issue_ctrl_regfile.sv
// Local register file for the issue stage.
// Ports: clk/rst (async active-high clear), two async operand read ports (raddr_a/b ->
// rdata_a/b), one async debug read port (dbg_addr -> dbg_data), one sync write port
// (we, waddr, wdata). Reads return the pre-write value in the write cycle (no bypass).
module alu_issue_ctrl_regfile #(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned NUM_REGS   = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [2:0]            raddr_a,
    input  logic [2:0]            raddr_b,
    input  logic [2:0]            dbg_addr,
    output logic [DATA_WIDTH-1:0] rdata_a,
    output logic [DATA_WIDTH-1:0] rdata_b,
    output logic [DATA_WIDTH-1:0] dbg_data,
    input  logic                  we,
    input  logic [2:0]            waddr,
    input  logic [DATA_WIDTH-1:0] wdata
);

    logic [DATA_WIDTH-1:0] mem_q [NUM_REGS];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(NUM_REGS); i++) begin
                mem_q[i] <= '0;
            end
        end else if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata_a  = mem_q[raddr_a];
    assign rdata_b  = mem_q[raddr_b];
    assign dbg_data = mem_q[dbg_addr];

endmodule

// File: rtl/alu_issue_ctrl.sv
// Issue/writeback stage for the 16-bit combinational ALU.
// Accepts one instruction per handshake on ibus (slave modport), reads rs1/rs2 from the
// local register file, drives registered ALU inputs (alu_a, alu_b, alu_x, alu_opcode),
// captures alu_out/alu_flags one cycle later and writes the result back the cycle after.
// Outputs: flags_q (flags of last retired ALU-class op), retire (pulse in WRITE),
// dbg_data (rf[dbg_addr], combinational). clk rising edge, rst async active-high.
module alu_issue_ctrl
    import alu_issue_ctrl_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned NUM_REGS   = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    alu_issue_ctrl_if.slave       ibus,
    output logic [DATA_WIDTH-1:0] alu_a,
    output logic [DATA_WIDTH-1:0] alu_b,
    output logic [3:0]            alu_x,
    output logic [3:0]            alu_opcode,
    input  logic [DATA_WIDTH-1:0] alu_out,
    input  logic [7:0]            alu_flags,
    output logic [7:0]            flags_q,
    output logic                  retire,
    input  logic [2:0]            dbg_addr,
    output logic [DATA_WIDTH-1:0] dbg_data
);

    state_e                state_q, state_d;
    logic [15:0]           ir_q;
    logic [DATA_WIDTH-1:0] res_q;
    logic [7:0]            flg_q;
    logic [DATA_WIDTH-1:0] rs1_data, rs2_data, wr_data;
    logic                  ready, accept, rf_we, flag_class;
    logic [3:0]            op_in, x_in, op_q;

    assign op_in  = ibus.instr[OPC_MSB:OPC_LSB];
    assign x_in   = ibus.instr[X_MSB:X_LSB];
    assign op_q   = ir_q[OPC_MSB:OPC_LSB];
    assign accept = ibus.instr_valid & ready;

    assign ibus.instr_ready = ready;
    assign retire           = (state_q == WRITE);
    assign flag_class       = (op_q != OP_NOP) && (op_q != OP_LDI);
    assign wr_data          = (op_q == OP_LDI)
                            ? {{(DATA_WIDTH-9){ir_q[IMM_MSB]}}, ir_q[IMM_MSB:0]}
                            : res_q;

    alu_issue_ctrl_regfile #(
        .DATA_WIDTH (DATA_WIDTH),
        .NUM_REGS   (NUM_REGS)
    ) u_regfile (
        .clk      (clk),
        .rst      (rst),
        .raddr_a  (ibus.instr[RS1_MSB:RS1_LSB]),
        .raddr_b  (ibus.instr[RS2_MSB:RS2_LSB]),
        .dbg_addr (dbg_addr),
        .rdata_a  (rs1_data),
        .rdata_b  (rs2_data),
        .dbg_data (dbg_data),
        .we       (rf_we),
        .waddr    (ir_q[RD_MSB:RD_LSB]),
        .wdata    (wr_data)
    );

    always_comb begin
        state_d = state_q;
        ready   = 1'b0;
        rf_we   = 1'b0;
        unique case (state_q)
            IDLE: begin
                ready = 1'b1;
                if (ibus.instr_valid) state_d = ISSUE;
            end
            ISSUE: state_d = WRITE;
            WRITE: begin
                rf_we   = (op_q != OP_NOP);
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ir_q       <= '0;
            alu_a      <= '0;
            alu_b      <= '0;
            alu_x      <= '0;
            alu_opcode <= '0;
            res_q      <= '0;
            flg_q      <= '0;
            flags_q    <= '0;
        end else begin
            if (accept) begin
                ir_q       <= ibus.instr;
                alu_a      <= rs1_data;
                alu_b      <= rs2_data;
                alu_x      <= x_in;
                alu_opcode <= alu_op_map(op_in, x_in);
            end
            if (state_q == ISSUE) begin
                res_q <= alu_out;
                flg_q <= alu_flags;
            end
            if (state_q == WRITE && flag_class) begin
                flags_q <= flg_q;
            end
        end
    end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed bench for alu_issue_ctrl with a small behavioural ALU in the loop.
module tb_alu_issue_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] alu_a, alu_b, alu_out, dbg_data;
    logic [3:0]  alu_x, alu_opcode;
    logic [7:0]  alu_flags, flags_q;
    logic        retire;
    logic [2:0]  dbg_addr;

    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    alu_issue_ctrl_if bus ();

    alu_issue_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .ibus       (bus.slave),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_x      (alu_x),
        .alu_opcode (alu_opcode),
        .alu_out    (alu_out),
        .alu_flags  (alu_flags),
        .flags_q    (flags_q),
        .retire     (retire),
        .dbg_addr   (dbg_addr),
        .dbg_data   (dbg_data)
    );

    always #5 clk = ~clk;

    // Behavioural ALU: flags = {V,0,0,0,0,N,C,Z}; zero-width rotate returns garbage.
    always_comb begin
        logic [16:0] s;
        logic        c, v;
        s = '0;
        c = 1'b0;
        v = 1'b0;
        case (alu_opcode)
            4'h0: s = {1'b0, alu_a};
            4'h8: begin
                s = {1'b0, alu_a} + 17'd1;
                v = (alu_a == 16'h7FFF);
            end
            4'hA: begin
                s = {1'b0, alu_a} + {1'b0, alu_b};
                v = (alu_a[15] == alu_b[15]) && (s[15] != alu_a[15]);
            end
            4'hD: s = {1'b0, alu_a >> alu_x};
            4'hE: s = (alu_x == 4'h0) ? 17'h0DEAD
                                      : {1'b0, (alu_a << alu_x) | (alu_a >> (5'd16 - {1'b0, alu_x}))};
            default: s = {1'b0, alu_a ^ alu_b};
        endcase
        if (alu_opcode == 4'h8 || alu_opcode == 4'hA) c = s[16];
        alu_out   = s[15:0];
        alu_flags = {v, 4'b0000, s[15], c, (s[15:0] == 16'h0000)};
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic check_reg(input logic [2:0] r, input logic [15:0] exp);
        dbg_addr = r;
        #1;
        check($sformatf("rf[%0d]", r), 32'(dbg_data), 32'(exp));
    endtask

    // One handshake, then walk ISSUE/WRITE/IDLE; returns the ALU inputs seen in ISSUE.
    task automatic do_instr(input logic [15:0] w, output logic [15:0] a_s, output logic [15:0] b_s,
                            output logic [3:0] x_s, output logic [3:0] opc_s);
        @(negedge clk);
        check("ready_idle", 32'(bus.instr_ready), 32'd1);
        bus.instr_valid = 1'b1;
        bus.instr       = w;
        @(posedge clk);
        #1 bus.instr_valid = 1'b0;
        @(negedge clk);
        a_s   = alu_a;
        b_s   = alu_b;
        x_s   = alu_x;
        opc_s = alu_opcode;
        check("retire_issue", 32'(retire), 32'd0);
        check("ready_issue", 32'(bus.instr_ready), 32'd0);
        @(negedge clk);
        check("retire_write", 32'(retire), 32'd1);
        @(negedge clk);
        check("retire_after", 32'(retire), 32'd0);
    endtask

    function automatic logic [15:0] enc_r(logic [3:0] op, logic [2:0] rd, logic [2:0] rs1,
                                          logic [2:0] rs2);
        return {op, rd, rs1, rs2, 3'b000};
    endfunction

    function automatic logic [15:0] enc_x(logic [3:0] op, logic [2:0] rd, logic [2:0] rs1,
                                          logic [3:0] x);
        return {op, rd, rs1, 2'b00, x};
    endfunction

    function automatic logic [15:0] enc_i(logic [2:0] rd, logic [8:0] imm);
        return {4'h1, rd, imm};
    endfunction

    logic [15:0] a_s, b_s;
    logic [3:0]  x_s, o_s;
    int          n_ret;

    initial begin
        rst             = 1'b1;
        bus.instr_valid = 1'b0;
        bus.instr       = '0;
        dbg_addr        = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_ready", 32'(bus.instr_ready), 32'd1);
        check("rst_retire", 32'(retire), 32'd0);
        check("rst_alu_a", 32'(alu_a), 32'd0);
        check("rst_alu_opc", 32'(alu_opcode), 32'd0);
        check("rst_flags", 32'(flags_q), 32'd0);
        check_reg(3'd7, 16'h0000);

        // LDI r1,#5 and LDI r2,#-3
        do_instr(enc_i(3'd1, 9'h005), a_s, b_s, x_s, o_s);
        check_reg(3'd1, 16'h0005);
        do_instr(enc_i(3'd2, 9'h1FD), a_s, b_s, x_s, o_s);
        check_reg(3'd2, 16'hFFFD);
        check("ldi_flags", 32'(flags_q), 32'h00);

        // ADD r3 = r1 + r2
        do_instr(enc_r(4'hA, 3'd3, 3'd1, 3'd2), a_s, b_s, x_s, o_s);
        check("add_opc", 32'(o_s), 32'hA);
        check("add_a", 32'(a_s), 32'h0005);
        check("add_b", 32'(b_s), 32'hFFFD);
        check_reg(3'd3, 16'h0002);
        check("add_flags", 32'(flags_q), 32'h02);

        // LDI leaves flags alone; SHR by 1 builds 0x7FFF; INC overflows
        do_instr(enc_i(3'd4, 9'h1FF), a_s, b_s, x_s, o_s);
        check_reg(3'd4, 16'hFFFF);
        check("ldi_keeps_flags", 32'(flags_q), 32'h02);
        do_instr(enc_x(4'hD, 3'd4, 3'd4, 4'd1), a_s, b_s, x_s, o_s);
        check("shr1_x", 32'(x_s), 32'd1);
        check_reg(3'd4, 16'h7FFF);
        check("shr1_flags", 32'(flags_q), 32'h00);
        do_instr(enc_r(4'h8, 3'd5, 3'd4, 3'd0), a_s, b_s, x_s, o_s);
        check_reg(3'd5, 16'h8000);
        check("inc_ovf_flag", 32'(flags_q[7]), 32'd1);
        check("inc_flags", 32'(flags_q), 32'h84);

        // Zero-width rotate becomes pass-A
        do_instr(enc_x(4'hE, 3'd6, 3'd2, 4'd0), a_s, b_s, x_s, o_s);
        check("rol0_opc", 32'(o_s), 32'h0);
        check("rol0_x", 32'(x_s), 32'h0);
        check("rol0_a", 32'(a_s), 32'hFFFD);
        check_reg(3'd6, 16'hFFFD);
        check("rol0_flags", 32'(flags_q), 32'h04);

        // MOV r0 <- r1
        do_instr(enc_r(4'h2, 3'd0, 3'd1, 3'd0), a_s, b_s, x_s, o_s);
        check("mov_opc", 32'(o_s), 32'h0);
        check_reg(3'd0, 16'h0005);
        check("mov_flags", 32'(flags_q), 32'h00);

        // Zero-width shift is passed unchanged
        do_instr(enc_x(4'hD, 3'd7, 3'd2, 4'd0), a_s, b_s, x_s, o_s);
        check("shr0_opc", 32'(o_s), 32'hD);
        check_reg(3'd7, 16'hFFFD);
        check("shr0_flags", 32'(flags_q), 32'h04);

        // NOP aimed at r1: no write, flags unchanged
        do_instr({4'h0, 3'd1, 9'h000}, a_s, b_s, x_s, o_s);
        check_reg(3'd1, 16'h0005);
        check("nop_flags", 32'(flags_q), 32'h04);

        // rd == rs1 == rs2
        do_instr(enc_r(4'hA, 3'd1, 3'd1, 3'd1), a_s, b_s, x_s, o_s);
        check_reg(3'd1, 16'h000A);
        check("self_add_flags", 32'(flags_q), 32'h00);

        // Back-to-back with instr_valid held high: accepts at edges 0, 3, 6
        n_ret = 0;
        for (int k = 0; k < 9; k++) begin
            @(negedge clk);
            check($sformatf("b2b_ready%0d", k), 32'(bus.instr_ready), 32'((k % 3) == 0));
            check($sformatf("b2b_retire%0d", k), 32'(retire), 32'((k % 3) == 2));
            if (retire) n_ret++;
            if (bus.instr_ready) begin
                bus.instr_valid = 1'b1;
                bus.instr       = enc_i(3'(k / 3 + 1), 9'(k / 3 + 1));
            end
        end
        @(negedge clk);
        bus.instr_valid = 1'b0;
        check("b2b_retires", 32'(n_ret), 32'd3);
        check_reg(3'd1, 16'h0001);
        check_reg(3'd2, 16'h0002);
        check_reg(3'd3, 16'h0003);

        // Reset during ISSUE of ADD r4
        @(negedge clk);
        bus.instr_valid = 1'b1;
        bus.instr       = enc_r(4'hA, 3'd4, 3'd1, 3'd2);
        @(posedge clk);
        #1 bus.instr_valid = 1'b0;
        @(negedge clk);
        check("pre_rst_opc", 32'(alu_opcode), 32'hA);
        rst = 1'b1;
        #1;
        check("async_alu_a", 32'(alu_a), 32'd0);
        check("async_alu_b", 32'(alu_b), 32'd0);
        check("async_alu_opc", 32'(alu_opcode), 32'd0);
        check("async_flags", 32'(flags_q), 32'd0);
        check("async_retire", 32'(retire), 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        n_ret = 0;
        repeat (3) begin
            @(negedge clk);
            if (retire) n_ret++;
        end
        check("rst_no_retire", 32'(n_ret), 32'd0);
        check("rst_idle_ready", 32'(bus.instr_ready), 32'd1);
        check_reg(3'd4, 16'h0000);
        check_reg(3'd1, 16'h0000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/alu_issue_ctrl.md
Name: alu_issue_ctrl

Overview:
- Upstream issue/writeback stage for the 16-bit combinational ALU.
- Accepts one instruction word per valid/ready handshake and reads two operands from a local register file.
- Drives the ALU operand, shift-amount and opcode inputs, then captures ALU_OUT/FLAGS_OUT and writes the result back.
- Strictly serial, one instruction in flight; 3-cycle issue-to-retire.

Parameters:
- DATA_WIDTH, 16, operand/result width; must match the ALU data_width.
- NUM_REGS, 8, register file depth; fixed at 8 for the 3-bit register fields.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- instr_valid  in  1  instruction word present.
- instr_ready  out  1  stage can accept (high only in IDLE).
- instr  in  16  [15:12] opcode, [11:9] rd, [8:6] rs1, [5:3] rs2, [3:0] shift amount X, [8:0] LDI immediate.
- alu_a  out  DATA_WIDTH  ALU operand A (registered).
- alu_b  out  DATA_WIDTH  ALU operand B (registered).
- alu_x  out  4  ALU shift amount (registered).
- alu_opcode  out  4  ALU opcode (registered).
- alu_out  in  DATA_WIDTH  ALU result (combinational return).
- alu_flags  in  8  ALU flags, bit0 zero … bit7 overflow.
- flags_q  out  8  flags of last retired ALU op.
- retire  out  1  one-cycle pulse on writeback.
- dbg_addr  in  3  debug read address.
- dbg_data  out  DATA_WIDTH  rf[dbg_addr], combinational.

Behaviour:
- Reset (async, rst=1):
  - State goes to IDLE; all 8 registers cleared to 0.
  - alu_a, alu_b, alu_x, alu_opcode, flags_q and retire go to 0.
  - instr_ready goes to 1 once rst is released.
  - A reset mid-instruction discards that instruction; no write occurs.
- FSM states: IDLE, ISSUE, WRITE.
- IDLE:
  - instr_ready=1.
  - On instr_valid&instr_ready, latch instr into the instruction register.
  - Load alu_a<=rf[rs1], alu_b<=rf[rs2], alu_x<=instr[3:0].
  - Load alu_opcode per the opcode rules below, then go to ISSUE.
  - Without a handshake, hold all outputs.
- ISSUE:
  - ALU inputs are stable for the full cycle.
  - At the edge, capture alu_out and alu_flags into internal result/flag registers, then go to WRITE.
- WRITE:
  - rf[rd]<=result; retire=1 for this cycle only.
  - flags_q<=captured flags for ALU-class ops.
  - Go to IDLE.
- Timing:
  - Handshake at edge 0; retire is high in cycle 2.
  - The new value is visible on dbg_data from cycle 3.
  - Next accept happens at edge 3 at the earliest.
- Opcode rules:
  - 0000 NOP: passes through ISSUE/WRITE; no rf write; flags_q unchanged; retire still pulses.
  - 0001 LDI: result = sign-extended instr[8:0]; ALU output ignored; rf written; flags_q unchanged.
  - 0010/0011 MOV: alu_opcode=0000 (ALU passes A); rd<=rf[rs1]; flags updated.
  - 0100–1111: alu_opcode=opcode; flags updated.
  - Rotate 1110/1111 with X=0: drive alu_opcode=0000 and alu_x=0, because zero-width rotate is undefined in the ALU. Result = A; flags updated.
  - Shift 1100/1101 with X=0: passed unchanged.
- For shift/rotate ops, alu_b carries rf[rs2] but it is don't-care.
- instr[3] is shared between rs2 and X; the decoder does not resolve it.
- Handshake details:
  - instr is sampled only in IDLE.
  - instr_valid may drop without penalty.
  - instr_valid held high while busy is not consumed until the return to IDLE.
- Same-register source and destination (rd==rs1==rs2) is legal; operands are read before the write.
- Write and debug read of the same register in the same cycle: dbg_data shows the old value (no bypass).
- Arithmetic: signed two's complement, DATA_WIDTH bits; the stage performs no arithmetic except LDI sign-extension.

Decomposition:
- alu_pkg:
  - opcode localparams (OP_NOP, OP_LDI, OP_MOV, OP_AND … OP_ROR);
  - flag bit indices (FLG_Z=0 … FLG_V=7);
  - instruction field bit positions;
  - FSM state enum {IDLE, ISSUE, WRITE}.
- Sub-module alu_regfile: 8×DATA_WIDTH, two async read ports plus one debug read port, one sync write port, async clear on rst.

Test Plan:
- Reset, then LDI r1,#5 and LDI r2,#-3 (0x1FD) → dbg r1=0x0005, r2=0xFFFD, retire pulses 2 cycles after each accept, flags_q=0.
- Add r3=r1+r2 (opcode 1010), with a model ALU → alu_opcode=1010, alu_a=5, alu_b=0xFFFD in ISSUE; r3=0x0002; flags_q matches model flags.
- Overflow: r1=0x7FFF (LDI 0xFF then 1000 INC chain, or preloaded) + 1 via 1000 → r=0x8000, flags_q[7]=1.
- Rotate left 1110 with X=0 on r1=0x1234 → alu_opcode=0000, alu_x=0, rd=0x1234.
- Back-to-back instr_valid held high for 3 instructions → instr_ready high only in IDLE; accepts at edges 0, 3, 6; exactly 3 retire pulses.
- rst asserted during ISSUE of ADD r4 → no write to r4 (reads 0), state IDLE, all outputs 0 immediately (async).
